// File: rtl/sprite_draw_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_draw_sequencer
//
// Walks the objects of one game frame (bird, upper pipe, lower pipe, coin) and
// emits one pixel per clock to a VGA framebuffer adapter. Each object is a
// rectangle scanned row-major, with the column counter running fastest.
// Objects that have nothing to draw are skipped without spending a cycle.
// Pixels falling off the 160x120 screen still take their cycle but are not
// written.
//
// Handshake: start is a one-cycle request. It is accepted only in IDLE and is
// ignored while a frame is running. There is no back-pressure. plot is a write
// strobe that qualifies x/y/colour in the same cycle. busy covers the frame
// from LATCH up to the last pixel. done pulses for one cycle in FINISH, and
// busy is already low in that cycle.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   start, erase           frame request; erase = draw in background colour
//   birdX, birdY           bird top-left corner
//   pipeX, gapY            pipe left column, first row of the gap
//   coinX, coinY, coinValid coin top-left corner and presence
//   x, y, colour, plot     registered pixel write to the VGA adapter
//   busy, done             frame status
//   dbgState               current FSM state (debug observation only)
// -----------------------------------------------------------------------------
module sprite_draw_sequencer #(
    parameter int BIRD_W = 4,
    parameter int BIRD_H = 4,
    parameter int PIPE_W = 8,
    parameter int GAP_H  = 40,
    parameter int COIN_S = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       erase,
    input  logic [7:0] birdX,
    input  logic [6:0] birdY,
    input  logic [7:0] pipeX,
    input  logic [6:0] gapY,
    input  logic [7:0] coinX,
    input  logic [6:0] coinY,
    input  logic       coinValid,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbgState
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        BIRD     = 3'd2,
        PIPE_TOP = 3'd3,
        PIPE_BOT = 3'd4,
        COIN     = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [8:0] SCREEN_H = 9'd120;

    localparam logic [7:0] BW = 8'(BIRD_W);
    localparam logic [7:0] BH = 8'(BIRD_H);
    localparam logic [7:0] PW = 8'(PIPE_W);
    localparam logic [7:0] CS = 8'(COIN_S);

    localparam logic [2:0] COL_ERASE = 3'b111;
    localparam logic [2:0] COL_BIRD  = 3'b110;
    localparam logic [2:0] COL_PIPE  = 3'b010;
    localparam logic [2:0] COL_COIN  = 3'b100;

    state_t     state, stateNext;
    logic [7:0] col, colNext;
    logic [7:0] row, rowNext;

    // Frame parameters frozen in LATCH.
    logic [7:0] latBirdX, latPipeX, latCoinX;
    logic [6:0] latBirdY, latGapY, latCoinY;
    logic       latErase, latCoinValid;

    // Geometry derived from the latched frame.
    logic [8:0] botTop;
    logic [7:0] botRows;
    logic       hasTop, hasBot;
    state_t     afterBird, afterTop, afterBot;

    logic [7:0] curW, curH;
    logic       lastCol, lastRow;

    // Pixel that becomes visible on the outputs in the next cycle.
    logic [7:0] srcBirdX;
    logic [6:0] srcBirdY;
    logic       srcErase;
    logic [7:0] ox, oy;
    logic [2:0] objColour;
    logic       nextDraw;
    logic [8:0] pixX, pixY;
    logic       clipped;

    // The lower pipe starts below the gap. The sum is 9 bits wide, so a large
    // gapY cannot wrap around into a bogus on-screen row.
    assign botTop  = 9'(latGapY) + 9'(GAP_H);
    assign hasBot  = (botTop < SCREEN_H);
    assign botRows = hasBot ? 8'(SCREEN_H - botTop) : 8'd0;
    assign hasTop  = (latGapY != 7'd0);

    // Skipping an object means choosing the next non-empty one directly.
    // This is why a skipped object costs no cycles.
    assign afterBot  = latCoinValid ? COIN : FINISH;
    assign afterTop  = hasBot ? PIPE_BOT : afterBot;
    assign afterBird = hasTop ? PIPE_TOP : afterTop;

    // Size of the rectangle being scanned in the current state.
    always_comb begin
        curW = 8'd1;
        curH = 8'd1;
        case (state)
            BIRD: begin
                curW = BW;
                curH = BH;
            end
            PIPE_TOP: begin
                curW = PW;
                curH = 8'(latGapY);
            end
            PIPE_BOT: begin
                curW = PW;
                curH = botRows;
            end
            COIN: begin
                curW = CS;
                curH = CS;
            end
            default: begin
                curW = 8'd1;
                curH = 8'd1;
            end
        endcase
    end

    assign lastCol = (col == curW - 8'd1);
    assign lastRow = (row == curH - 8'd1);

    // Next-state and counter logic.
    always_comb begin
        stateNext = state;
        colNext   = col;
        rowNext   = row;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = LATCH;
                end
            end
            LATCH: begin
                stateNext = BIRD;
                colNext   = 8'd0;
                rowNext   = 8'd0;
            end
            BIRD, PIPE_TOP, PIPE_BOT, COIN: begin
                if (!lastCol) begin
                    colNext = col + 8'd1;
                end else begin
                    colNext = 8'd0;
                    if (!lastRow) begin
                        rowNext = row + 8'd1;
                    end else begin
                        rowNext = 8'd0;
                        case (state)
                            BIRD:     stateNext = afterBird;
                            PIPE_TOP: stateNext = afterTop;
                            PIPE_BOT: stateNext = afterBot;
                            default:  stateNext = FINISH;
                        endcase
                    end
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The first bird pixel is registered at the end of LATCH, in the same edge
    // that latches the inputs. That pixel must therefore come from the live
    // inputs rather than from the latched copies.
    assign srcBirdX = (state == LATCH) ? birdX : latBirdX;
    assign srcBirdY = (state == LATCH) ? birdY : latBirdY;
    assign srcErase = (state == LATCH) ? erase : latErase;

    always_comb begin
        ox        = 8'd0;
        oy        = 8'd0;
        objColour = COL_BIRD;
        nextDraw  = 1'b0;
        case (stateNext)
            BIRD: begin
                ox        = srcBirdX;
                oy        = 8'(srcBirdY);
                objColour = COL_BIRD;
                nextDraw  = 1'b1;
            end
            PIPE_TOP: begin
                ox        = latPipeX;
                oy        = 8'd0;
                objColour = COL_PIPE;
                nextDraw  = 1'b1;
            end
            PIPE_BOT: begin
                ox        = latPipeX;
                oy        = botTop[7:0];
                objColour = COL_PIPE;
                nextDraw  = 1'b1;
            end
            COIN: begin
                ox        = latCoinX;
                oy        = 8'(latCoinY);
                objColour = COL_COIN;
                nextDraw  = 1'b1;
            end
            default: begin
                ox        = 8'd0;
                oy        = 8'd0;
                objColour = COL_BIRD;
                nextDraw  = 1'b0;
            end
        endcase
    end

    assign pixX    = 9'(ox) + 9'(colNext);
    assign pixY    = 9'(oy) + 9'(rowNext);
    assign clipped = (pixX >= SCREEN_W) || (pixY >= SCREEN_H);

    // State register and scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            col   <= 8'd0;
            row   <= 8'd0;
        end else begin
            state <= stateNext;
            col   <= colNext;
            row   <= rowNext;
        end
    end

    // Frame parameter latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latBirdX     <= 8'd0;
            latBirdY     <= 7'd0;
            latPipeX     <= 8'd0;
            latGapY      <= 7'd0;
            latCoinX     <= 8'd0;
            latCoinY     <= 7'd0;
            latErase     <= 1'b0;
            latCoinValid <= 1'b0;
        end else if (state == LATCH) begin
            latBirdX     <= birdX;
            latBirdY     <= birdY;
            latPipeX     <= pipeX;
            latGapY      <= gapY;
            latCoinX     <= coinX;
            latCoinY     <= coinY;
            latErase     <= erase;
            latCoinValid <= coinValid;
        end
    end

    // Registered pixel outputs. Outside the draw states, x/y/colour keep the
    // last pixel and plot stays low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
        end else if (nextDraw) begin
            x      <= pixX[7:0];
            y      <= pixY[6:0];
            colour <= srcErase ? COL_ERASE : objColour;
            plot   <= !clipped;
        end else begin
            plot   <= 1'b0;
        end
    end

    assign busy     = (state == LATCH) || (state == BIRD) || (state == PIPE_TOP) ||
                      (state == PIPE_BOT) || (state == COIN);
    assign done     = (state == FINISH);
    assign dbgState = state;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for sprite_draw_sequencer.
//
// For every accepted start, a reference model lays out the frame's rectangles
// with plain loops. It queues each expected visible pixel, tagged with the
// cycle in which it should appear, and it queues the expected done cycle.
// A monitor on the falling edge pops and compares these entries whenever the
// DUT strobes plot or done.
// -----------------------------------------------------------------------------
module tb_sprite_draw_sequencer;

  localparam int EW = 50;  // {cycle[31:0], x[7:0], y[6:0], colour[2:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       erase;
  logic [7:0] birdX, pipeX, coinX;
  logic [6:0] birdY, gapY, coinY;
  logic       coinValid;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  logic [2:0] dbgState;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;
  int mdl_n;

  logic [EW-1:0] exp_q[$];
  int            exp_done_q[$];

  sprite_draw_sequencer #(
    .BIRD_W(4), .BIRD_H(4), .PIPE_W(8), .GAP_H(40), .COIN_S(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .erase(erase),
    .birdX(birdX), .birdY(birdY), .pipeX(pipeX), .gapY(gapY),
    .coinX(coinX), .coinY(coinY), .coinValid(coinValid),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
    .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_no++;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc_no);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_rect(input int s, input int ox, input int oy, input int w, input int h,
                           input int c3);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int px, py;
        px = ox + c;
        py = oy + r;
        if (px < 160 && py < 120)
          exp_q.push_back({32'(s + 2 + mdl_n), 8'(px), 7'(py), 3'(c3)});
        mdl_n++;
      end
    end
  endtask

  task automatic model_frame(input int s, input bit er, input int bx, input int by,
                             input int px, input int gy, input int cx, input int cy,
                             input bit cv);
    int top;
    mdl_n = 0;
    push_rect(s, bx, by, 4, 4, er ? 7 : 6);
    push_rect(s, px, 0, 8, gy, er ? 7 : 2);
    top = gy + 40;
    if (top < 120) push_rect(s, px, top, 8, 120 - top, er ? 7 : 2);
    if (cv) push_rect(s, cx, cy, 2, 2, er ? 7 : 4);
    exp_done_q.push_back(s + 2 + mdl_n);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; this cycle is "cycle 0" of the frame.
  task automatic issue(input bit er, input int bx, input int by, input int px, input int gy,
                       input int cx, input int cy, input bit cv);
    erase = er; birdX = 8'(bx); birdY = 7'(by); pipeX = 8'(px); gapY = 7'(gy);
    coinX = 8'(cx); coinY = 7'(cy); coinValid = cv;
    start = 1'b1;
    model_frame(cyc_no, er, bx, by, px, gy, cx, cy, cv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((exp_done_q.size() != 0 || busy) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got no done within %0d cycles, expected done", budget);
      exp_q.delete();
      exp_done_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (plot) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_plot: got plot x=%0d y=%0d, expected no plot (cycle %0d)",
                   x, y, cyc_no);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("pix_cycle", 64'(cyc_no), 64'(e[49:18]));
          check("pix_x", x, e[17:10]);
          check("pix_y", y, e[9:3]);
          check("pix_colour", colour, e[2:0]);
        end
      end
      if (done) begin
        check("done_busy_low", busy, 0);
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc_no);
        end else begin
          check("done_cycle", 64'(cyc_no), 64'(exp_done_q.pop_front()));
          check("pixels_left_at_done", 64'(exp_q.size()), 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; erase = 1'b0;
    birdX = 8'd0; birdY = 7'd0; pipeX = 8'd0; gapY = 7'd0;
    coinX = 8'd0; coinY = 7'd0; coinValid = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    // Full frame: 16 + 240 + 400 + 4 pixels.
    issue(0, 10, 20, 100, 30, 50, 60, 1);
    wait_done(3000);

    // Skips: no upper pipe, no coin.
    issue(0, 10, 20, 100, 0, 50, 60, 0);
    wait_done(3000);

    // Clipping at the right edge of the screen.
    issue(0, 10, 20, 156, 30, 50, 60, 1);
    wait_done(3000);

    // Erase: same scan, background colour throughout.
    issue(1, 10, 20, 100, 30, 50, 60, 1);
    wait_done(3000);

    // Lower pipe absent (gapY+40 >= 120), bird and coin clipped at corners.
    issue(0, 158, 118, 3, 80, 159, 119, 1);
    wait_done(3000);

    // Robustness: inputs change and start pulses while the frame runs.
    issue(0, 10, 20, 100, 30, 50, 60, 1);
    for (int i = 0; i < 5; i++) begin
      repeat (7) @(posedge clk);
      #1;
      birdX = 8'($urandom_range(0, 255));
      pipeX = 8'($urandom_range(0, 255));
      gapY  = 7'($urandom_range(0, 127));
      erase = 1'($urandom_range(0, 1));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(3000);

    // start in the FINISH cycle is ignored; start in the next IDLE cycle is taken.
    issue(0, 30, 40, 60, 20, 70, 80, 1);
    begin
      int f;
      f = exp_done_q[0];
      while (cyc_no < f) begin
        @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      issue(0, 30, 40, 60, 20, 70, 80, 1);
    end
    wait_done(3000);

    // Reset while the lower pipe is being drawn: abort, no done pulse.
    issue(0, 10, 20, 100, 30, 50, 60, 1);
    repeat (2 + 16 + 240 + 20) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_frame");
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset_held");
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_abort", done, 0);
    check("idle_after_abort", busy, 0);
    issue(0, 12, 22, 90, 25, 40, 44, 1);
    wait_done(3000);

    // Random frames.
    for (int i = 0; i < 12; i++) begin
      issue(1'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      wait_done(3000);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_pixels_left", 64'(exp_q.size()), 0);
    check("final_done_left", 64'(exp_done_q.size()), 0);
    check("final_idle_plot", plot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_draw_sequencer.md
SPRITE_DRAW_SEQUENCER -- requirements
Module: sprite_draw_sequencer

Interface
REQ-001 Parameter BIRD_W, default 4, meaning bird sprite width in pixels.
REQ-002 Parameter BIRD_H, default 4, meaning bird sprite height in pixels.
REQ-003 Parameter PIPE_W, default 8, meaning pipe column width in pixels.
REQ-004 Parameter GAP_H, default 40, meaning vertical pipe gap height in pixels.
REQ-005 Parameter COIN_S, default 2, meaning coin sprite side length (square).
REQ-006 clk  input  1  single system clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to draw one full frame of objects.
REQ-009 erase  input  1  sampled with start; 1 = draw all objects in background colour.
REQ-010 birdX  input  8 / birdY  input  7  bird top-left corner.
REQ-011 pipeX  input  8 / gapY  input  7  pipe left column / first row of gap.
REQ-012 coinX  input  8 / coinY  input  7 / coinValid  input  1  coin top-left corner and presence.
REQ-013 x  output  8 / y  output  7 / colour  output  3  registered pixel to VGA adapter.
REQ-014 plot  output  1  registered write strobe, valid with x/y/colour in the same cycle.
REQ-015 busy  output  1  high from the cycle after accepted start until done.
REQ-016 done  output  1  one-cycle pulse on completion (feeds controller outputFinish).

Function
REQ-017 States SHALL be IDLE, LATCH, BIRD, PIPE_TOP, PIPE_BOT, COIN, FINISH.
REQ-018 IDLE->LATCH on start=1; start SHALL be ignored in every state other than IDLE.
REQ-019 LATCH SHALL capture all position inputs, erase and coinValid; later input changes SHALL NOT affect the frame in progress.
REQ-020 Each draw state SHALL scan its rectangle row-major (column counter fastest), one pixel per cycle, no stall cycles.
REQ-021 BIRD rectangle: columns birdX..birdX+BIRD_W-1, rows birdY..birdY+BIRD_H-1.
REQ-022 PIPE_TOP rectangle: columns pipeX..pipeX+PIPE_W-1, rows 0..gapY-1; state SHALL be skipped entirely when gapY=0.
REQ-023 PIPE_BOT rectangle: same columns, rows gapY+GAP_H..119; skipped when gapY+GAP_H>=120 (sum computed at 8 bits, no wrap).
REQ-024 COIN rectangle: COIN_S x COIN_S at coinX,coinY; skipped when latched coinValid=0.
REQ-025 Sequence SHALL be BIRD->PIPE_TOP->PIPE_BOT->COIN->FINISH, skipping per REQ-022..024; a skipped state consumes zero cycles.
REQ-026 Clipping: pixel with computed x>=160 or y>=120 (9-bit/8-bit intermediate) SHALL emit plot=0 but still consume its cycle.
REQ-027 Colour: erase=1 -> 3'b111 for all objects; else bird 3'b110, pipe 3'b010, coin 3'b100.
REQ-028 Latency: start in cycle 0 -> LATCH cycle 1 -> first bird pixel (plot=1 if unclipped) in cycle 2.
REQ-029 FINISH SHALL assert done=1 for exactly one cycle, busy=0 in that same cycle, then return to IDLE.
REQ-030 start asserted in the FINISH cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-031 Outside draw states plot SHALL be 0; x/y/colour hold last value.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, plot=0, busy=0, done=0, x=0, y=0, colour=0, counters=0, independent of clk.
REQ-033 reset asserted mid-frame SHALL abort the frame with no done pulse; first start after release SHALL begin a fresh frame.

Verification
REQ-034 Full frame: birdX=10,birdY=20,pipeX=100,gapY=30,coinValid=1,erase=0 -> 660 plot cycles (16+240+400+4), first plot x=10,y=20,colour=110 at cycle 2, done once.
REQ-035 Skips: gapY=0,coinValid=0, others as REQ-034 -> PIPE_TOP absent, 16+640=656 plot cycles, done at cycle 2+656.
REQ-036 Clipping: pipeX=156,gapY=30 -> pipe pixels with x 156..159 plot=1, x>=160 plot=0; cycle count unchanged from REQ-034.
REQ-037 Erase: erase=1 with REQ-034 inputs -> identical x/y sequence, every plot colour=111.
REQ-038 Robustness: change birdX mid-frame, pulse start while busy -> no effect; assert reset in PIPE_BOT -> outputs zero at once, no done, next start redraws from bird.
